alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have these ports (name direction width meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard held and incoming ops
- in_valid  in  1  upstream op present
- in_ready  out  1  stage accepts op this cycle
- in_funct  in  3  op select
- in_rd, in_rs, in_rt  in  3 each  dest/src register indices
- in_use_imm  in  1  B from immediate, not rt
- in_imm  in  6  signed immediate
- wb_en  in  1  writeback strobe
- wb_addr  in  3  writeback index
- wb_data  in  16  writeback value
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream consumes
- alu_a, alu_b  out  16 each  ALU operands
- alu_operation  out  3  ALU op code
- alu_binvert, alu_carryin  out  1 each  ALU qualifiers
- out_rd  out  3  destination index
- out_illegal  out  1  funct was illegal

Function
REQ-003 SHALL contain an 8x16 register file; r0 reads 0 and ignores writes.
REQ-004 SHALL apply writes at the clk edge when wb_en=1 and wb_addr!=0.
REQ-005 SHALL read rs/rt with write-through bypass: a same-cycle matching nonzero wb_addr returns wb_data.
REQ-006 SHALL compute in_ready = !flush && (!out_valid || out_ready).
REQ-007 SHALL accept an op when in_valid && in_ready and register all outputs at that edge (latency 1).
REQ-008 SHALL use a two-state FSM: EMPTY->FULL on accept; FULL->EMPTY on out_ready && !accept; FULL->FULL on accept or !out_ready.
REQ-009 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-010 SHALL decode in_funct as {operation, binvert, carryin}:
- 000 add -> 100,1,0
- 001 sub -> 100,0,1
- 010 and -> 000,1,0
- 011 or -> 001,1,0
- 100 nor -> 010,1,0
- 101 xor -> 011,1,0
REQ-011 SHALL encode funct 110/111 as add (100,1,0), pass them downstream and set out_illegal=1.
REQ-012 SHALL drive alu_b with the register value, or with in_imm sign-extended to 16 bits when in_use_imm=1.
REQ-013 SHALL give flush priority: next out_valid=0, no op accepted, register-file write still performed.
REQ-014 SHALL perform no hazard detection; consumer forwarding covers in-flight out_rd.

Reset
REQ-015 SHALL on rst force state EMPTY and clear every register-file entry and every output to 0.
REQ-016 SHALL on rst mid-operation drop the held op and ignore same-cycle wb_en and in_valid.
REQ-017 SHALL hold in_ready=0 during the rst cycle.

Configuration
REQ-018 SHALL, when macro ALU_ISSUE_IMM_EN is defined, implement the immediate path per REQ-012.
REQ-019 SHALL, when ALU_ISSUE_IMM_EN is undefined, ignore in_use_imm and in_imm and always source alu_b from rt.

Structure
REQ-020 SHALL take funct codes, ALU operation codes and REG_W=16, REG_N=8 from the shared package alu_pkg.
REQ-021 SHALL implement the register file as sub-module alu_regfile; decode and handshake stay in the top.

Verification
REQ-022 SHALL cover: write r3=0x1234, r4=0x0F0F; issue funct 011 rs=3 rt=4 -> next cycle out_valid=1, A=0x1234, B=0x0F0F, op=001, binvert=1, carryin=0.
REQ-023 SHALL cover: issue funct 001 while wb_en writes r2=0xBEEF in the same cycle, rs=2 -> A=0xBEEF, op=100, binvert=0, carryin=1.
REQ-024 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> next op loaded, no loss or duplication.
REQ-025 SHALL cover: in_use_imm=1, in_imm=6'b111110 -> B=0xFFFE with macro, B=rt value without macro.
REQ-026 SHALL cover: funct 111 -> out_illegal=1, op=100; write to r0 then read -> 0x0000.
REQ-027 SHALL cover: flush or rst while FULL with in_valid=1 -> next cycle out_valid=0, op dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: register file geometry, funct
// codes, downstream ALU operation codes and the funct -> ALU control decode.
// Latency: n/a (package). Backpressure: n/a (package).
package alu_pkg;

    // Register file geometry
    localparam int REG_W  = 16;
    localparam int REG_N  = 8;
    localparam int REG_AW = 3;

    // Immediate field width (sign-extended to REG_W when used)
    localparam int IMM_W  = 6;

    // Upstream funct encodings
    typedef enum logic [2:0] {
        FUNCT_ADD  = 3'b000,
        FUNCT_SUB  = 3'b001,
        FUNCT_AND  = 3'b010,
        FUNCT_OR   = 3'b011,
        FUNCT_NOR  = 3'b100,
        FUNCT_XOR  = 3'b101,
        FUNCT_RSV6 = 3'b110,
        FUNCT_RSV7 = 3'b111
    } funct_e;

    // Downstream ALU operation encodings
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_NOR = 3'b010,
        ALU_XOR = 3'b011,
        ALU_ADD = 3'b100
    } alu_op_e;

    // Decoded control word handed to the ALU
    typedef struct packed {
        alu_op_e operation;
        logic    binvert;
        logic    carryin;
        logic    illegal;
    } alu_ctrl_t;

    // Issue-stage occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_e;

    // Map funct onto the ALU's {operation, binvert, carryin} qualifiers.
    // The downstream ALU treats binvert=1 as "B passes through unmodified"
    // and binvert=0 as "B inverted", so subtract is binvert=0 + carryin=1.
    // Reserved functs are issued as a plain add and flagged illegal so the
    // consumer can raise an exception without stalling this stage.
    function automatic alu_ctrl_t decode_funct(input logic [2:0] funct);
        alu_ctrl_t c;
        c.operation = ALU_ADD;
        c.binvert   = 1'b1;
        c.carryin   = 1'b0;
        c.illegal   = 1'b0;
        case (funct)
            FUNCT_ADD: begin
                c.operation = ALU_ADD;
            end
            FUNCT_SUB: begin
                c.operation = ALU_ADD;
                c.binvert   = 1'b0;
                c.carryin   = 1'b1;
            end
            FUNCT_AND: begin
                c.operation = ALU_AND;
            end
            FUNCT_OR: begin
                c.operation = ALU_OR;
            end
            FUNCT_NOR: begin
                c.operation = ALU_NOR;
            end
            FUNCT_XOR: begin
                c.operation = ALU_XOR;
            end
            default: begin
                c.operation = ALU_ADD;
                c.illegal   = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file, two combinational read ports with write-through bypass.
// Latency: reads 0 cycles (bypass returns same-cycle write data); writes land at clk edge.
// Backpressure: none; a write is always taken, r0 is hardwired to zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all entries)
//   we/waddr/wdata    write strobe, index, value
//   raddr_a/rdata_a   read port A
//   raddr_b/rdata_b   read port B
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [REG_W-1:0]  wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [REG_W-1:0]  rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [REG_W-1:0]  rdata_b
);

    logic [REG_W-1:0] mem [REG_N];

    // Writes to r0 are dropped here so bypass and storage agree on r0 == 0.
    logic wr_hit;
    assign wr_hit = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-through: a read of the index being written this cycle sees the
    // new value, so an op issued alongside its producer's writeback is correct.
    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            if (wr_hit && (waddr == raddr_a)) begin
                rdata_a = wdata;
            end else begin
                rdata_a = mem[raddr_a];
            end
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            if (wr_hit && (waddr == raddr_b)) begin
                rdata_b = wdata;
            end else begin
                rdata_b = mem[raddr_b];
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: reads operands, decodes funct, presents a registered ALU op.
// Latency: 1 cycle from accept to out_valid; single-entry output holding register.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); outputs frozen while stalled.
//
// Optional feature: define ALU_ISSUE_IMM_EN to source alu_b from the
// sign-extended in_imm when in_use_imm=1. Without it alu_b always comes from rt.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   flush                             drop held op and refuse the incoming one
//   in_valid/in_ready                 upstream handshake
//   in_funct, in_rd, in_rs, in_rt     op select, destination and source indices
//   in_use_imm, in_imm                immediate select and 6-bit signed immediate
//   wb_en, wb_addr, wb_data           register file writeback
//   out_valid/out_ready               downstream handshake
//   alu_a, alu_b                      operands
//   alu_operation, alu_binvert,
//   alu_carryin                       ALU control
//   out_rd, out_illegal               destination index, illegal-funct flag
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_funct,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic              in_use_imm,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [REG_W-1:0]  wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_W-1:0]  alu_a,
    output logic [REG_W-1:0]  alu_b,
    output logic [2:0]        alu_operation,
    output logic              alu_binvert,
    output logic              alu_carryin,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_illegal
);

    issue_state_e     state;
    logic             accept;
    logic [REG_W-1:0] rs_data;
    logic [REG_W-1:0] rt_data;
    logic [REG_W-1:0] b_next;
    alu_ctrl_t        ctrl_next;

    // ------------------------------------------------------------------
    // Register file. Its own reset has priority over the write strobe, so a
    // writeback coincident with rst is discarded.
    // ------------------------------------------------------------------
    alu_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (in_rs),
        .rdata_a (rs_data),
        .raddr_b (in_rt),
        .rdata_b (rt_data)
    );

    // ------------------------------------------------------------------
    // Handshake. rst also closes the input so nothing appears accepted in
    // the reset cycle.
    // ------------------------------------------------------------------
    assign in_ready = !rst && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Operand B select and decode
    // ------------------------------------------------------------------
`ifdef ALU_ISSUE_IMM_EN
    always_comb begin
        b_next = rt_data;
        if (in_use_imm) begin
            b_next = {{(REG_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        end
    end
`else
    // Immediate inputs are intentionally ignored in this build.
    logic unused_imm;
    assign unused_imm = &{1'b0, in_use_imm, in_imm};
    assign b_next     = rt_data;
`endif

    assign ctrl_next = decode_funct(in_funct);

    // ------------------------------------------------------------------
    // Occupancy FSM with registered outputs. The payload registers only load
    // on accept, which is what keeps them stable across a stall. Flush clears
    // only out_valid; the stale payload is harmless behind out_valid=0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_EMPTY;
            out_valid     <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= '0;
            alu_binvert   <= 1'b0;
            alu_carryin   <= 1'b0;
            out_rd        <= '0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase

            if (accept) begin
                alu_a         <= rs_data;
                alu_b         <= b_next;
                alu_operation <= ctrl_next.operation;
                alu_binvert   <= ctrl_next.binvert;
                alu_carryin   <= ctrl_next.carryin;
                out_rd        <= in_rd;
                out_illegal   <= ctrl_next.illegal;
            end
        end
    end

endmodule
